dmux_rr_ctrl: RTL and testbench
===============================

Name: dmux_rr_ctrl

Overview:
- Round-robin controller that sequences a 1:NCH demultiplexer.
- Accepts words from a single valid/ready source and delivers each word, in turn, to one of NCH sinks.
- Drives the demux select and a one-hot out_valid.
- Sits between a serial producer and the demux fan-out in the combinational-logic demo designs.

Parameters:
- NCH, 4: number of output channels; power of two, 2..16.
- DW, 8: data word width.
- SELW, $clog2(NCH): select width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- en  in  1  controller enable.
- ch_mask  in  NCH  per-channel enable; bit i=1 means channel i participates.
- in_data  in  DW  source word.
- in_valid  in  1  source word valid.
- in_ready  out  1  controller can accept a word.
- out_data  out  DW  registered word, shared by all sinks.
- out_valid  out  NCH  one-hot valid; the demux of the valid bit by sel.
- out_ready  in  NCH  per-sink ready.
- sel  out  SELW  current demux select.
- busy  out  1  high while a word is held.

Behaviour:
- Reset (rstn=0, asynchronous):
  - state=IDLE, ptr=0, sel=0, out_data=0, out_valid=0.
  - in_ready=0 and busy=0.
  - A reset in mid-transfer drops the held word.
- FSM has two states, IDLE and DRIVE.
- IDLE:
  - in_ready = en & |ch_mask (combinational).
  - On in_valid & in_ready:
    - out_data <= in_data.
    - sel <= pick(ptr, ch_mask), the first enabled channel at or after ptr, circular.
    - Go to DRIVE.
- DRIVE:
  - out_valid = one-hot(sel); busy=1; in_ready=0.
  - out_data and sel hold stable until the handshake.
  - On out_ready[sel]:
    - ptr <= (sel+1) mod NCH.
    - out_valid deasserts next cycle.
    - Go to IDLE.
  - out_ready of non-selected channels is ignored.
- Latency: capture at edge N, out_valid high from N+1. Peak throughput is 1 word per 2 cycles.
- en or ch_mask changes during DRIVE do not abort the transfer. The held word always completes to the selected sel.
- ch_mask=0 or en=0 in IDLE: in_ready=0 and no capture.
- Wrap-around: after a delivery on channel NCH-1, ptr returns to 0.
- Skipping: a disabled channel is skipped at pick time. With a single enabled channel, every word goes to that channel.
- ptr is unchanged while IDLE.

Optional Feature:
- Macro DMUX_SKIP_BUSY_EN.
- Defined:
  - pick() prefers the first channel at or after ptr that is enabled AND has out_ready=1 at capture.
  - If no enabled channel is ready, it falls back to the plain round-robin pick.
  - The rest of the behaviour is unchanged.
- Undefined:
  - Strict round-robin; out_ready does not affect selection.

Decomposition:
- Shared include dmux_defs.vh:
  - state encodings IDLE=1'b0, DRIVE=1'b1.
  - SELW computation macro.
- Sub-module dmux_rr_pick:
  - combinational.
  - Inputs: ptr, mask (optionally ANDed with out_ready).
  - Outputs: selected index and a found flag.
  - Instantiated once.

Test Plan:
- NCH=4, ch_mask=4'b1111, all out_ready=1, in_data 0xA0,0xA1,0xA2,0xA3,0xA4 back-to-back -> delivered on channels 0,1,2,3,0 in that order; in_ready low every DRIVE cycle; out_valid one-hot each word.
- ch_mask=4'b1010, 4 words -> channels 1,3,1,3; channels 0 and 2 never see out_valid.
- Word 0x55 captured to channel 2, out_ready[2]=0 for 5 cycles, out_ready[0]=1 -> out_valid=4'b0100 and out_data=0x55 stable for 5 cycles; completes only when out_ready[2]=1.
- ch_mask cleared to 0 during DRIVE -> the current word still completes; afterwards in_ready=0 and in_valid is ignored.
- rstn pulsed low during DRIVE -> out_valid=0, busy=0, sel=0 immediately; the next word after reset goes to channel 0.
- With DMUX_SKIP_BUSY_EN, ch_mask=4'b1111, ptr=0, out_ready=4'b0100 at capture -> word goes to channel 2; next ptr=3.

Source files
------------

// File: rtl/dmux_rr_ctrl_pkg.sv
// Shared definitions for the round-robin demux controller.
// FSM state encodings and the select-width helper live here so the top,
// the interface and the picker agree on them.
// Optional feature macro: DMUX_SKIP_BUSY_EN (see dmux_rr_ctrl.sv).
package dmux_rr_ctrl_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRIVE = 1'b1
  } dmux_state_e;

  // Select width for a channel count; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmux_rr_ctrl_if.sv
// Source-side and sink-side bus of the round-robin demux controller.
// slave  : the controller's view.
// master : the producer/sink environment's view.
import dmux_rr_ctrl_pkg::*;

interface dmux_rr_ctrl_if #(
  parameter int NCH = 4,
  parameter int DW  = 8
);
  localparam int SELW = sel_width(NCH);

  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   out_data;
  logic [NCH-1:0]  out_valid;
  logic [NCH-1:0]  out_ready;
  logic [SELW-1:0] sel;
  logic            busy;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, sel, busy
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, sel, busy
  );

endinterface

// File: rtl/dmux_rr_ctrl_pick.sv
// Circular first-set search: returns the first index at or after ptr_i
// whose mask bit is set, wrapping at NCH (NCH is a power of two, so the
// SELW-bit add wraps for free).
import dmux_rr_ctrl_pkg::*;

module dmux_rr_pick #(
  parameter int NCH  = 4,
  parameter int SELW = sel_width(NCH)
) (
  input  logic [SELW-1:0] ptr_i,
  input  logic [NCH-1:0]  mask_i,
  output logic [SELW-1:0] idx_o,
  output logic            found_o
);

  logic [SELW-1:0] cand;

  // Scan from the farthest offset down so the nearest hit wins.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    cand    = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      cand = ptr_i + SELW'(i);
      if (mask_i[cand]) begin
        idx_o   = cand;
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmux_rr_ctrl.sv
// Round-robin controller for a 1:NCH demux: takes words from one
// valid/ready source and hands each, in turn, to the next enabled sink.
// Optional feature macro: DMUX_SKIP_BUSY_EN -- when defined, the pick
// prefers enabled channels that are ready at capture time, falling back
// to plain round-robin when none is ready.
//
// state | meaning
// IDLE  | no word held; in_ready = en & |ch_mask
// DRIVE | word held on out_data, out_valid one-hot on sel until out_ready[sel]
import dmux_rr_ctrl_pkg::*;

module dmux_rr_ctrl #(
  parameter int NCH = 4,
  parameter int DW  = 8
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            en,
  input  logic [NCH-1:0]  ch_mask,
  dmux_rr_ctrl_if.slave   bus
);

  localparam int SELW = sel_width(NCH);

  dmux_state_e     state_q, state_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [DW-1:0]   data_q, data_d;

  logic [NCH-1:0]  pick_mask;
  logic [SELW-1:0] pick_idx;
  logic            pick_found;
  logic            in_ready;
  logic            capture;
  logic            deliver;
  logic [NCH-1:0]  out_valid;
  logic            busy;

`ifdef DMUX_SKIP_BUSY_EN
  logic [NCH-1:0] rdy_mask;
  assign rdy_mask  = ch_mask & bus.out_ready;
  assign pick_mask = (|rdy_mask) ? rdy_mask : ch_mask;
`else
  assign pick_mask = ch_mask;
`endif

  dmux_rr_pick #(.NCH(NCH), .SELW(SELW)) u_pick (
    .ptr_i   (ptr_q),
    .mask_i  (pick_mask),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  assign capture = in_ready & bus.in_valid & pick_found;
  assign deliver = (state_q == ST_DRIVE) & bus.out_ready[sel_q];

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: capture moves to DRIVE, the selected sink's ready returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (capture) state_d = ST_DRIVE;
      ST_DRIVE: if (deliver) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs; in_ready is also held low while reset is asserted.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = '0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE:  in_ready = rstn & en & (|ch_mask);
      ST_DRIVE: begin
        out_valid = NCH'(1) << sel_q;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next values: load word and select on capture, advance ptr on delivery.
  always_comb begin
    data_d = data_q;
    sel_d  = sel_q;
    ptr_d  = ptr_q;
    if (capture) begin
      data_d = bus.in_data;
      sel_d  = pick_idx;
    end
    if (deliver) ptr_d = sel_q + SELW'(1);
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q <= '0;
      sel_q  <= '0;
      ptr_q  <= '0;
    end else begin
      data_q <= data_d;
      sel_q  <= sel_d;
      ptr_q  <= ptr_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_data  = data_q;
  assign bus.out_valid = out_valid;
  assign bus.sel       = sel_q;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_dmux_rr_ctrl.sv
// Directed, table-driven bench for dmux_rr_ctrl (NCH=4, DW=8).
module tb_dmux_rr_ctrl;

  logic       clk;
  logic       rstn;
  logic       en;
  logic [3:0] ch_mask;

  int n_checks = 0;
  int n_errors = 0;

  dmux_rr_ctrl_if #(.NCH(4), .DW(8)) bus ();

  dmux_rr_ctrl #(.NCH(4), .DW(8)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .en      (en),
    .ch_mask (ch_mask),
    .bus     (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       en;
    logic [3:0] mask;
    logic       vld;
    logic [7:0] din;
    logic [3:0] rdy;
    logic       x_ird;
    logic [3:0] x_ov;
    logic [7:0] x_dat;
    logic [1:0] x_sel;
    logic       x_busy;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic ird, input logic [3:0] ov,
                         input logic [7:0] dat, input logic [1:0] s, input logic b);
    chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(ird));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    chk({tag, ".out_data"},  32'(bus.out_data),  32'(dat));
    chk({tag, ".sel"},       32'(bus.sel),       32'(s));
    chk({tag, ".busy"},      32'(bus.busy),      32'(b));
  endtask

  task automatic drive(input logic e, input logic [3:0] m, input logic v,
                       input logic [7:0] d, input logic [3:0] r);
    en            = e;
    ch_mask       = m;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  initial begin
    // en mask vld din rdy | in_ready out_valid out_data sel busy
    // All channels, all sinks ready: A0..A4 to channels 0,1,2,3,0.
    vt.push_back('{1'b1, 4'hF, 1'b1, 8'hA0, 4'hF, 1'b1, 4'h0, 8'h00, 2'd0, 1'b0});
    vt.push_back('{1'b1, 4'hF, 1'b1, 8'hA1, 4'hF, 1'b0, 4'h1, 8'hA0, 2'd0, 1'b1});
    vt.push_back('{1'b1, 4'hF, 1'b1, 8'hA1, 4'hF, 1'b1, 4'h0, 8'hA0, 2'd0, 1'b0});
    vt.push_back('{1'b1, 4'hF, 1'b1, 8'hA2, 4'hF, 1'b0, 4'h2, 8'hA1, 2'd1, 1'b1});
    vt.push_back('{1'b1, 4'hF, 1'b1, 8'hA2, 4'hF, 1'b1, 4'h0, 8'hA1, 2'd1, 1'b0});
    vt.push_back('{1'b1, 4'hF, 1'b1, 8'hA3, 4'hF, 1'b0, 4'h4, 8'hA2, 2'd2, 1'b1});
    vt.push_back('{1'b1, 4'hF, 1'b1, 8'hA3, 4'hF, 1'b1, 4'h0, 8'hA2, 2'd2, 1'b0});
    vt.push_back('{1'b1, 4'hF, 1'b1, 8'hA4, 4'hF, 1'b0, 4'h8, 8'hA3, 2'd3, 1'b1});
    vt.push_back('{1'b1, 4'hF, 1'b1, 8'hA4, 4'hF, 1'b1, 4'h0, 8'hA3, 2'd3, 1'b0});
    vt.push_back('{1'b1, 4'hF, 1'b0, 8'h00, 4'hF, 1'b0, 4'h1, 8'hA4, 2'd0, 1'b1});
    // Mask 1010 from ptr=1: B0..B3 to channels 1,3,1,3.
    vt.push_back('{1'b1, 4'hA, 1'b1, 8'hB0, 4'hF, 1'b1, 4'h0, 8'hA4, 2'd0, 1'b0});
    vt.push_back('{1'b1, 4'hA, 1'b1, 8'hB1, 4'hF, 1'b0, 4'h2, 8'hB0, 2'd1, 1'b1});
    vt.push_back('{1'b1, 4'hA, 1'b1, 8'hB1, 4'hF, 1'b1, 4'h0, 8'hB0, 2'd1, 1'b0});
    vt.push_back('{1'b1, 4'hA, 1'b1, 8'hB2, 4'hF, 1'b0, 4'h8, 8'hB1, 2'd3, 1'b1});
    vt.push_back('{1'b1, 4'hA, 1'b1, 8'hB2, 4'hF, 1'b1, 4'h0, 8'hB1, 2'd3, 1'b0});
    vt.push_back('{1'b1, 4'hA, 1'b1, 8'hB3, 4'hF, 1'b0, 4'h2, 8'hB2, 2'd1, 1'b1});
    vt.push_back('{1'b1, 4'hA, 1'b1, 8'hB3, 4'hF, 1'b1, 4'h0, 8'hB2, 2'd1, 1'b0});
    vt.push_back('{1'b1, 4'hA, 1'b0, 8'h00, 4'hF, 1'b0, 4'h8, 8'hB3, 2'd3, 1'b1});
    // en=0 and mask=0 in IDLE: no ready, no capture.
    vt.push_back('{1'b0, 4'hF, 1'b1, 8'hCC, 4'hF, 1'b0, 4'h0, 8'hB3, 2'd3, 1'b0});
    vt.push_back('{1'b1, 4'h0, 1'b1, 8'hCC, 4'hF, 1'b0, 4'h0, 8'hB3, 2'd3, 1'b0});
    // 0x55 to channel 2, stalled 5 cycles while only sink 0 is ready.
    vt.push_back('{1'b1, 4'h4, 1'b1, 8'h55, 4'h1, 1'b1, 4'h0, 8'hB3, 2'd3, 1'b0});
    for (int i = 0; i < 5; i++)
      vt.push_back('{1'b1, 4'h4, 1'b0, 8'h00, 4'h1, 1'b0, 4'h4, 8'h55, 2'd2, 1'b1});
    vt.push_back('{1'b1, 4'h4, 1'b0, 8'h00, 4'h4, 1'b0, 4'h4, 8'h55, 2'd2, 1'b1});
    vt.push_back('{1'b1, 4'h4, 1'b0, 8'h00, 4'hF, 1'b1, 4'h0, 8'h55, 2'd2, 1'b0});
    // Single enabled channel from ptr=3 wraps to 2; mask/en dropped mid-DRIVE.
    vt.push_back('{1'b1, 4'h4, 1'b1, 8'h66, 4'hF, 1'b1, 4'h0, 8'h55, 2'd2, 1'b0});
    vt.push_back('{1'b0, 4'h0, 1'b0, 8'h00, 4'hF, 1'b0, 4'h4, 8'h66, 2'd2, 1'b1});
    vt.push_back('{1'b1, 4'h0, 1'b1, 8'h77, 4'hF, 1'b0, 4'h0, 8'h66, 2'd2, 1'b0});
    vt.push_back('{1'b1, 4'h0, 1'b1, 8'h77, 4'hF, 1'b0, 4'h0, 8'h66, 2'd2, 1'b0});

    rstn = 1'b0;
    drive(1'b1, 4'hF, 1'b0, 8'h00, 4'hF);
    #2;
    chk_all("reset", 1'b0, 4'h0, 8'h00, 2'd0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    foreach (vt[k]) begin
      drive(vt[k].en, vt[k].mask, vt[k].vld, vt[k].din, vt[k].rdy);
      @(negedge clk);
      chk_all($sformatf("vec%0d", k), vt[k].x_ird, vt[k].x_ov, vt[k].x_dat,
              vt[k].x_sel, vt[k].x_busy);
      @(posedge clk);
      #1;
    end

    // Reset during DRIVE: ptr is 3, word 0x99 held on channel 3.
    drive(1'b1, 4'hF, 1'b1, 8'h99, 4'h0);
    @(negedge clk);
    chk_all("rst_pre", 1'b1, 4'h0, 8'h66, 2'd2, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk_all("rst_hold", 1'b0, 4'h8, 8'h99, 2'd3, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    chk_all("rst_async", 1'b0, 4'h0, 8'h00, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    drive(1'b1, 4'hF, 1'b1, 8'h5A, 4'hF);
    @(negedge clk);
    chk_all("rst_idle", 1'b1, 4'h0, 8'h00, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk_all("rst_next", 1'b0, 4'h1, 8'h5A, 2'd0, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_all("rst_done", 1'b1, 4'h0, 8'h5A, 2'd0, 1'b0);

`ifdef DMUX_SKIP_BUSY_EN
    // ptr=1, only sink 2 ready at capture: skip busy channel 1, go to 2.
    @(posedge clk);
    #1;
    drive(1'b1, 4'hF, 1'b1, 8'h3C, 4'h4);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk_all("skip_cap", 1'b0, 4'h4, 8'h3C, 2'd2, 1'b1);
    @(posedge clk);
    #1;
    drive(1'b1, 4'hF, 1'b1, 8'h3D, 4'hF);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk_all("skip_next", 1'b0, 4'h8, 8'h3D, 2'd3, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
